change_dispenser: RTL and testbench

- Output-side counterpart to the vending controller's money intake. The controller accepts 1/5/10/20/50 notes as single-cycle pulses; this block returns change_money as single-cycle denomination pulses, using a greedy largest-first order.
- Sits between the controller's change_money/sys_Change path and the LED/actuator outputs.
- Runs in auto-paced mode or manual mode. In manual mode each debounced sys_Change pulse releases one note.

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/denom_select.sv | 30 +++
 rtl/change_dispenser.sv | 129 ++++++++++++
 tb/tb_change_dispenser.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: note values, dispenser state encoding and the
// denomination code also used by the controller's note-intake decode.
package vend_pkg;

    localparam int unsigned DEN_1  = 1;
    localparam int unsigned DEN_5  = 5;
    localparam int unsigned DEN_10 = 10;
    localparam int unsigned DEN_20 = 20;
    localparam int unsigned DEN_50 = 50;

    // One-hot dispenser states.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_SELECT = 5'b00010,
        ST_ISSUE  = 5'b00100,
        ST_GAP    = 5'b01000,
        ST_DONE   = 5'b10000
    } disp_state_e;

    typedef enum logic [2:0] {
        DC_NONE   = 3'd0,
        DC_ONE    = 3'd1,
        DC_FIVE   = 3'd2,
        DC_TEN    = 3'd3,
        DC_TWENTY = 3'd4,
        DC_FIFTY  = 3'd5
    } denom_e;

    function automatic int unsigned denom_value(denom_e code);
        int unsigned val;
        val = 0;
        case (code)
            DC_ONE:    val = DEN_1;
            DC_FIVE:   val = DEN_5;
            DC_TEN:    val = DEN_10;
            DC_TWENTY: val = DEN_20;
            DC_FIFTY:  val = DEN_50;
            default:   val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/denom_select.sv
// Greedy largest-first denomination picker: the biggest note that does not
// exceed the amount still owed. Purely combinational.
module denom_select
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    output denom_e           code,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        code = DC_NONE;
        if (remaining >= AMT_W'(DEN_50)) begin
            code = DC_FIFTY;
        end else if (remaining >= AMT_W'(DEN_20)) begin
            code = DC_TWENTY;
        end else if (remaining >= AMT_W'(DEN_10)) begin
            code = DC_TEN;
        end else if (remaining >= AMT_W'(DEN_5)) begin
            code = DC_FIVE;
        end else if (remaining >= AMT_W'(DEN_1)) begin
            code = DC_ONE;
        end
    end

    assign value = AMT_W'(denom_value(code));

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount as single-cycle note pulses, largest
// note first, either self-paced or one note per step pulse.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PACE_CYCLES = 4,
    parameter int unsigned AMT_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [AMT_W-1:0] amount,
    input  logic             auto_mode,
    input  logic             step,
    input  logic             abort,
    output logic             note_fifty,
    output logic             note_twenty,
    output logic             note_ten,
    output logic             note_five,
    output logic             note_one,
    output logic [AMT_W-1:0] remaining,
    output logic [7:0]       notes_out,
    output logic             busy,
    output logic             done
);

    disp_state_e      state;
    logic [7:0]       gap_cnt;
    denom_e           sel_code;
    logic [AMT_W-1:0] sel_value;

    denom_select #(
        .AMT_W(AMT_W)
    ) u_denom_select (
        .remaining(remaining),
        .code     (sel_code),
        .value    (sel_value)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= 8'd0;
            remaining   <= '0;
            notes_out   <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            note_fifty  <= 1'b0;
            note_twenty <= 1'b0;
            note_ten    <= 1'b0;
            note_five   <= 1'b0;
            note_one    <= 1'b0;
        end else begin
            done        <= 1'b0;
            note_fifty  <= 1'b0;
            note_twenty <= 1'b0;
            note_ten    <= 1'b0;
            note_five   <= 1'b0;
            note_one    <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (load) begin
                        remaining <= amount;
                        notes_out <= 8'd0;
                        if (amount != '0) begin
                            state <= ST_SELECT;
                            busy  <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (auto_mode || step) begin
                        // Note lines are registered so the pulse coincides with ISSUE.
                        state       <= ST_ISSUE;
                        note_fifty  <= (sel_code == DC_FIFTY);
                        note_twenty <= (sel_code == DC_TWENTY);
                        note_ten    <= (sel_code == DC_TEN);
                        note_five   <= (sel_code == DC_FIVE);
                        note_one    <= (sel_code == DC_ONE);
                    end
                end
                ST_ISSUE: begin
                    remaining <= remaining - sel_value;
                    if (notes_out != 8'hFF) begin
                        notes_out <= notes_out + 8'd1;
                    end
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= 8'(PACE_CYCLES - 1);
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == 8'd0) begin
                        if (remaining != '0) begin
                            state <= ST_SELECT;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected note/done events with their
// cycle numbers are queued at stimulus time and matched by a pin monitor.
module tb_change_dispenser;

    localparam int P = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       auto_mode = 1'b1;
    logic       step = 1'b0;
    logic       abort = 1'b0;
    logic       note_fifty, note_twenty, note_ten, note_five, note_one;
    logic [7:0] remaining;
    logic [7:0] notes_out;
    logic       busy;
    logic       done;

    change_dispenser #(
        .PACE_CYCLES(P),
        .AMT_W      (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .load       (load),
        .amount     (amount),
        .auto_mode  (auto_mode),
        .step       (step),
        .abort      (abort),
        .note_fifty (note_fifty),
        .note_twenty(note_twenty),
        .note_ten   (note_ten),
        .note_five  (note_five),
        .note_one   (note_one),
        .remaining  (remaining),
        .notes_out  (notes_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // val = note value, or 0 for the done pulse.
    typedef struct {
        int val;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge sys_clk) begin
        int nv;
        int v;
        ev_t e;
        nv = int'(note_fifty === 1'b1) + int'(note_twenty === 1'b1) + int'(note_ten === 1'b1)
           + int'(note_five === 1'b1) + int'(note_one === 1'b1);
        v = 0;
        if (note_fifty === 1'b1) v = 50;
        else if (note_twenty === 1'b1) v = 20;
        else if (note_ten === 1'b1) v = 10;
        else if (note_five === 1'b1) v = 5;
        else if (note_one === 1'b1) v = 1;
        if (nv > 1) check("note_onehot", nv, 1);
        if (nv > 0 || done === 1'b1) begin
            if (nv > 0) check("done_with_note", int'(done === 1'b1), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", v, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_value", v, e.val);
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    // Greedy model: queue every note and the done pulse for a load sampled at edge l.
    function automatic int push_run(input int amt, input int l);
        int rem, c, n, d;
        rem = amt;
        c = l + 1;
        n = 0;
        while (rem > 0) begin
            if (rem >= 50) d = 50;
            else if (rem >= 20) d = 20;
            else if (rem >= 10) d = 10;
            else if (rem >= 5) d = 5;
            else d = 1;
            exp_q.push_back('{d, c});
            rem -= d;
            n++;
            c += P + 2;
        end
        if (n == 0) exp_q.push_back('{0, l});
        else exp_q.push_back('{0, c - (P + 2) + P + 1});
        return n;
    endfunction

    task automatic do_load(input int amt);
        load = 1'b1;
        amount = 8'(amt);
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge sys_clk);
        step = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge sys_clk);
            t++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge sys_clk);
    endtask

    task automatic auto_case(input int amt, input string tag);
        int l, n;
        l = cyc + 1;
        n = push_run(amt, l);
        do_load(amt);
        drain(tag);
        check({tag, "_notes"}, int'(notes_out), n);
        check({tag, "_rem"}, int'(remaining), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int l, s;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_notes", int'({note_fifty, note_twenty, note_ten, note_five, note_one}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rem", int'(remaining), 0);
        check("rst_cnt", int'(notes_out), 0);

        auto_case(86, "a86");
        auto_case(0, "a0");
        auto_case(255, "a255");

        // Manual mode: nothing without step, step in GAP dropped, step after done ignored.
        auto_mode = 1'b0;
        do_load(7);
        repeat (10) @(negedge sys_clk);
        check("man_wait_busy", int'(busy), 1);
        check("man_wait_rem", int'(remaining), 7);
        check("man_wait_cnt", int'(notes_out), 0);
        s = cyc + 1;
        exp_q.push_back('{5, s});
        pulse_step();
        @(negedge sys_clk);
        pulse_step();
        repeat (5) @(negedge sys_clk);
        check("man_rem1", int'(remaining), 2);
        check("man_cnt1", int'(notes_out), 1);
        s = cyc + 1;
        exp_q.push_back('{1, s});
        pulse_step();
        repeat (7) @(negedge sys_clk);
        s = cyc + 1;
        exp_q.push_back('{1, s});
        exp_q.push_back('{0, s + P + 1});
        pulse_step();
        drain("man");
        pulse_step();
        repeat (8) @(negedge sys_clk);
        check("man_cnt_end", int'(notes_out), 3);
        check("man_busy_end", int'(busy), 0);
        check("man_rem_end", int'(remaining), 0);
        auto_mode = 1'b1;

        // Abort during GAP after the first note.
        l = cyc + 1;
        exp_q.push_back('{50, l + 1});
        do_load(75);
        @(negedge sys_clk);
        @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("abg_busy", int'(busy), 0);
        repeat (6) @(negedge sys_clk);
        check("abg_rem", int'(remaining), 25);
        check("abg_cnt", int'(notes_out), 1);
        check("abg_q", exp_q.size(), 0);
        auto_case(25, "a25");

        // Abort coincident with ISSUE.
        l = cyc + 1;
        exp_q.push_back('{20, l + 1});
        do_load(30);
        @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        check("abi_busy", int'(busy), 0);
        check("abi_rem", int'(remaining), 10);
        check("abi_cnt", int'(notes_out), 1);
        repeat (8) @(negedge sys_clk);
        check("abi_busy_late", int'(busy), 0);

        // Synchronous reset in GAP.
        l = cyc + 1;
        exp_q.push_back('{50, l + 1});
        do_load(86);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mrst_rem", int'(remaining), 0);
        check("mrst_cnt", int'(notes_out), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        repeat (8) @(negedge sys_clk);
        check("mrst_busy_late", int'(busy), 0);
        check("mrst_q", exp_q.size(), 0);

        // load while busy is ignored.
        l = cyc + 1;
        void'(push_run(86, l));
        do_load(86);
        @(negedge sys_clk);
        @(negedge sys_clk);
        load = 1'b1;
        amount = 8'd200;
        @(negedge sys_clk);
        load = 1'b0;
        check("ign_rem", int'(remaining), 36);
        check("ign_cnt", int'(notes_out), 1);
        check("ign_busy", int'(busy), 1);
        drain("ign");
        check("ign_cnt_end", int'(notes_out), 5);
        check("ign_rem_end", int'(remaining), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
